mul_arbiter: RTL
================

MUL_ARBITER -- requirements
Module: mul_arbiter

Interface
REQ-001 SHALL have parameter SIZE, default 8, operand width in bits (result is 2*SIZE).
REQ-002 SHALL have port clk, input, 1, single system clock; all state on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-004 SHALL have ports req0/req1, input, 1, request from requester 0/1; held high until matching ack.
REQ-005 SHALL have ports a0/b0 and a1/b1, input, SIZE, unsigned operands of requester 0/1; valid while its req is high.
REQ-006 SHALL have ports ack0/ack1, output, 1, one-cycle pulse: operands of that requester captured.
REQ-007 SHALL have ports done0/done1, output, 1, one-cycle pulse: result belongs to that requester.
REQ-008 SHALL have port result, output, 2*SIZE, unsigned product a*b of the last completed operation.
REQ-009 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-010 SHALL have port owner, output, 1, index of requester granted the current or last operation.

Function
REQ-011 SHALL share one internal iterative shift-add multiplier between the two requesters; one operation in flight at a time.
REQ-012 SHALL implement FSM states IDLE, RUN and DONE; no other reachable states.
REQ-013 IDLE: on an edge with req0 or req1 high, SHALL capture the winner's a/b, set owner, clear bit counter and accumulator, assert that ack for the following cycle, and go to RUN.
REQ-014 Arbitration SHALL be round-robin: with one request, grant it; with both, grant the requester not equal to owner.
REQ-015 RUN: each edge SHALL process one multiplier bit (LSB first): add shifted multiplicand to accumulator if bit set; after exactly SIZE RUN edges go to DONE.
REQ-016 DONE: result SHALL be updated and the owner's done pulse asserted for exactly one cycle; next edge returns to IDLE.
REQ-017 Latency SHALL be fixed: done asserted SIZE cycles after the ack cycle, independent of operand values (zero operands included).
REQ-018 Throughput SHALL be one operation per SIZE+2 cycles; requests while busy SHALL be ignored (no ack) until IDLE.
REQ-019 Accumulation SHALL be full 2*SIZE width, no truncation; max (2^SIZE-1)^2 exact.
REQ-020 result SHALL hold its value from DONE until the next DONE; operand changes after ack SHALL not affect it.
REQ-021 ack0 and ack1 SHALL never both be high; likewise done0 and done1.

Reset
REQ-022 Asserting rst SHALL immediately force IDLE, counter/accumulator to 0, result to 0, ack0/ack1/done0/done1/busy to 0, owner to 1 (so requester 0 wins the first tie).
REQ-023 Reset mid-RUN SHALL abort the operation with no done pulse; first request after release is handled normally.

Configuration
REQ-024 Macro MUL_ARBITER_FIXED_PRIORITY_EN: when defined, arbitration SHALL be fixed priority (requester 0 always wins a tie); when undefined, round-robin per REQ-014. All other behaviour identical.

Verification
REQ-025 SIZE=8, req0 only, a0=12,b0=10 -> ack0 one cycle, done0 8 cycles later, result=120 (0x0078), owner=0.
REQ-026 req0 and req1 held high together after reset, a0=3,b0=5,a1=7,b1=9 -> grants alternate 0,1,0,...; results 15,63,15; each op 10 cycles apart (macro defined: always requester 0, result 15).
REQ-027 a1=255,b1=255 -> result=65025 (0xFE01); a0=0,b0=200 -> result=0 with identical latency.
REQ-028 req1 raised while busy with requester 0 -> no ack1 until IDLE; ack1 on the first IDLE edge, result of op 0 unchanged until op 1's DONE.
REQ-029 rst asserted 4 cycles into RUN -> busy=0, result=0 immediately, no done pulse; subsequent req0 a0=2,b0=3 -> result=6.
REQ-030 Operands changed on the cycle after ack0 (a0 5->99) -> result uses captured value.

Source files
------------

// File: rtl/mul_arbiter_if.sv
// Purpose : handshake/operand/result bundle between two requesters and mul_arbiter.
// Latency : n/a (wires only).
// Backpressure: requesters hold req and operands until the matching ack pulse.
//
// Ports (all inside the interface):
//   req0/req1   requester -> arbiter, held high until ack
//   a0/b0,a1/b1 requester -> arbiter, unsigned operands (SIZE bits)
//   ack0/ack1   arbiter -> requester, one-cycle operand-capture pulse
//   done0/done1 arbiter -> requester, one-cycle result-ready pulse
//   result      arbiter -> requester, 2*SIZE-bit product of last completed op
//   busy, owner arbiter status
interface mul_arbiter_if #(
  parameter int SIZE = 8
);
  logic              req0;
  logic              req1;
  logic [SIZE-1:0]   a0;
  logic [SIZE-1:0]   b0;
  logic [SIZE-1:0]   a1;
  logic [SIZE-1:0]   b1;
  logic              ack0;
  logic              ack1;
  logic              done0;
  logic              done1;
  logic [2*SIZE-1:0] result;
  logic              busy;
  logic              owner;

  modport master (
    output req0, req1, a0, b0, a1, b1,
    input  ack0, ack1, done0, done1, result, busy, owner
  );

  modport slave (
    input  req0, req1, a0, b0, a1, b1,
    output ack0, ack1, done0, done1, result, busy, owner
  );
endinterface

// File: rtl/mul_arbiter.sv
// Purpose : two-requester arbiter sharing one iterative shift-add multiplier.
// Latency : ack one cycle after the granting edge; done exactly SIZE cycles after ack.
// Backpressure: one op in flight; requests seen while busy are simply not acked.
//
// Ports: clk, rst (async, active-high), bus (mul_arbiter_if.slave).
// Optional build macro MUL_ARBITER_FIXED_PRIORITY_EN: when defined, requester 0
// always wins a tie; otherwise ties alternate round-robin against owner.
module mul_arbiter #(
  parameter int SIZE = 8
) (
  input  logic         clk,
  input  logic         rst,
  mul_arbiter_if.slave bus
);

  localparam int RW = 2 * SIZE;
  localparam int CW = $clog2(SIZE + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            owner_q, owner_d;
  logic [RW-1:0]   mcand_q, mcand_d;   // multiplicand, shifted left each RUN edge
  logic [SIZE-1:0] mplier_q, mplier_d; // multiplier, shifted right each RUN edge
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [RW-1:0]   acc_q, acc_d;
  logic [RW-1:0]   result_q, result_d;
  logic            ack0_q, ack0_d;
  logic            ack1_q, ack1_d;
  logic            done0_q, done0_d;
  logic            done1_q, done1_d;

  logic            any_req;
  logic            grant;
  logic [RW-1:0]   acc_add;

  assign any_req = bus.req0 | bus.req1;
  // Accumulator value after processing the current multiplier LSB.
  assign acc_add = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

  always_comb begin
    grant = 1'b0;
`ifdef MUL_ARBITER_FIXED_PRIORITY_EN
    grant = bus.req0 ? 1'b0 : 1'b1;
`else
    // On a tie, hand the multiplier to whoever did not have it last.
    if (bus.req0 && bus.req1) begin
      grant = ~owner_q;
    end else begin
      grant = bus.req0 ? 1'b0 : 1'b1;
    end
`endif
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    result_d = result_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    done0_d  = 1'b0;
    done1_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (any_req) begin
          owner_d  = grant;
          mcand_d  = {{SIZE{1'b0}}, (grant ? bus.a1 : bus.a0)};
          mplier_d = grant ? bus.b1 : bus.b0;
          cnt_d    = '0;
          acc_d    = '0;
          ack0_d   = ~grant;
          ack1_d   = grant;
          state_d  = RUN;
        end
      end
      RUN: begin
        acc_d    = acc_add;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        // Last bit: publish the product so it is visible alongside done.
        if (cnt_q == CW'(SIZE - 1)) begin
          state_d  = DONE;
          result_d = acc_add;
          done0_d  = ~owner_q;
          done1_d  = owner_q;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= 1'b1;  // requester 0 wins the first tie
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
    end
  end

  assign bus.ack0   = ack0_q;
  assign bus.ack1   = ack1_q;
  assign bus.done0  = done0_q;
  assign bus.done1  = done1_q;
  assign bus.result = result_q;
  assign bus.busy   = (state_q != IDLE);
  assign bus.owner  = owner_q;

endmodule
